// File: rtl/phoenix_ni_tx_if.sv
// phoenix_ni_tx_if -- host-side and router-side signals of the Phoenix
// network-interface transmitter, bundled in one interface.
//
// Handshake rules:
//   descriptor : transfer on the rising edge where pkt_valid && pkt_ready.
//   payload    : each wr_en edge offers one flit; dropped when fifo_full.
//   link       : a flit transfers on the rising edge where tx && credit_i.
//                Once tx rises it stays high with data_out stable until
//                that transfer happens.
//
// Modports:
//   master : host and router side (drives descriptors, payload and credit)
//   slave  : the transmitter itself
interface phoenix_ni_tx_if #(
  parameter int TAM_FLIT = 16,
  parameter int DEPTH    = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                pkt_valid;
  logic                pkt_ready;
  logic [TAM_FLIT-1:0] pkt_target;
  logic [TAM_FLIT-1:0] pkt_size;
  logic                wr_en;
  logic [TAM_FLIT-1:0] wr_data;
  logic                fifo_full;
  logic [CW-1:0]       fifo_count;
  logic                overflow;
  logic                busy;
  logic                clock_tx;
  logic                tx;
  logic [TAM_FLIT-1:0] data_out;
  logic                credit_i;

  modport master (
    output pkt_valid, pkt_target, pkt_size, wr_en, wr_data, credit_i,
    input  pkt_ready, fifo_full, fifo_count, overflow, busy, clock_tx,
           tx, data_out
  );

  modport slave (
    input  pkt_valid, pkt_target, pkt_size, wr_en, wr_data, credit_i,
    output pkt_ready, fifo_full, fifo_count, overflow, busy, clock_tx,
           tx, data_out
  );
endinterface

// File: rtl/phoenix_ni_tx.sv
// phoenix_ni_tx -- network-interface transmitter for the router local port.
//
// The host posts a descriptor (target, size) and fills a payload FIFO; the
// block serialises header flit, size flit and `size` payload flits onto the
// router local input with the rx/data_in/credit_o handshake.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   ni           phoenix_ni_tx_if.slave (descriptor, FIFO write, link side)
//   dbg_state_o  current FSM state (IDLE=0, HEADER=1, SIZE=2, PAYLOAD=3)
module phoenix_ni_tx #(
  parameter int TAM_FLIT = 16,
  parameter int DEPTH    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  phoenix_ni_tx_if.slave       ni,
  output logic [1:0]           dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_SIZE    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TAM_FLIT-1:0] target_q, target_d;
  logic [TAM_FLIT-1:0] size_q, size_d;
  logic [TAM_FLIT-1:0] remaining_q, remaining_d;
  // Last flit shown on data_out; data_out falls back to it while tx=0.
  logic [TAM_FLIT-1:0] last_q;

  logic [TAM_FLIT-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                overflow_q;

  logic                fifo_empty, fifo_full;
  logic                push, pop;
  logic                tx_c;
  logic [TAM_FLIT-1:0] flit_c;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  // Full is judged on the occupancy at the start of the cycle, so a write
  // while full is dropped even when a pop happens on the same edge.
  assign push       = ni.wr_en && !fifo_full;

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    size_d      = size_q;
    remaining_d = remaining_q;
    tx_c        = 1'b0;
    flit_c      = last_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ni.pkt_valid) begin
          target_d = ni.pkt_target;
          size_d   = ni.pkt_size;
          state_d  = S_HEADER;
        end
      end
      S_HEADER: begin
        tx_c   = 1'b1;
        flit_c = target_q;
        if (ni.credit_i) state_d = S_SIZE;
      end
      S_SIZE: begin
        tx_c   = 1'b1;
        flit_c = size_q;
        if (ni.credit_i) begin
          if (size_q == '0) begin
            state_d = S_IDLE;
          end else begin
            remaining_d = size_q;
            state_d     = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        // First-word-fall-through head; an empty FIFO makes a bubble but
        // never ends the packet early.
        tx_c = !fifo_empty;
        if (!fifo_empty) flit_c = mem_q[rd_ptr_q];
        if (tx_c && ni.credit_i) begin
          pop         = 1'b1;
          remaining_d = remaining_q - TAM_FLIT'(1);
          if (remaining_q == TAM_FLIT'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      size_q      <= '0;
      remaining_q <= '0;
      last_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      size_q      <= size_d;
      remaining_q <= remaining_d;
      if (tx_c) last_q <= flit_c;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (ni.wr_en && fifo_full) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= ni.wr_data;
  end

  assign ni.pkt_ready  = (state_q == S_IDLE);
  assign ni.busy       = (state_q != S_IDLE);
  assign ni.tx         = tx_c;
  assign ni.data_out   = flit_c;
  assign ni.fifo_full  = fifo_full;
  assign ni.fifo_count = count_q;
  assign ni.overflow   = overflow_q;
  assign ni.clock_tx   = clock;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_phoenix_ni_tx.sv
module tb_phoenix_ni_tx;
  localparam int W     = 16;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  phoenix_ni_tx_if #(.TAM_FLIT(W), .DEPTH(DEPTH)) bus ();
  logic [1:0] dbg_state;

  phoenix_ni_tx #(.TAM_FLIT(W), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .ni          (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  // Output stream of a packet: target, size, then `size` flits taken from
  // the FIFO in write order. The FIFO is a plain queue capped at DEPTH.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];
  bit           m_active;
  int           m_sent;
  int           m_size;
  logic [W-1:0] m_target;
  logic [W-1:0] m_last;
  bit           m_ovf;

  task automatic clear_model();
    exp_q.delete();
    m_active = 0;
    m_sent   = 0;
    m_size   = 0;
    m_target = '0;
    m_last   = '0;
    m_ovf    = 0;
  endtask

  // ---------------- compare process ----------------
  logic         c_tx;
  logic [W-1:0] c_flit;
  bit           c_full, c_was_active;

  always @(negedge clock) begin
    if (reset) begin
      c_tx   = m_active && (m_sent < 2 || exp_q.size() > 0);
      c_flit = (m_sent == 0) ? m_target :
               (m_sent == 1) ? W'(m_size) :
               (exp_q.size() > 0 ? exp_q[0] : '0);
      check("busy", bus.busy, m_active);
      check("pkt_ready", bus.pkt_ready, !m_active);
      check("tx", bus.tx, c_tx);
      if (c_tx) check("data_out", bus.data_out, c_flit);
      else      check("data_hold", bus.data_out, m_last);
      check("fifo_count", bus.fifo_count, exp_q.size());
      check("fifo_full", bus.fifo_full, exp_q.size() == DEPTH);
      check("overflow", bus.overflow, m_ovf);
      check("clock_tx", bus.clock_tx, clock);
      if (bus.tx && bus.credit_i) out_log.push_back(bus.data_out);

      // advance the model to the state after the coming rising edge
      c_full       = (exp_q.size() == DEPTH);
      c_was_active = m_active;
      if (c_tx) m_last = c_flit;
      if (c_tx && bus.credit_i) begin
        if (m_sent >= 2) void'(exp_q.pop_front());
        m_sent++;
        if (m_sent == m_size + 2) m_active = 0;
      end
      if (!c_was_active && bus.pkt_valid) begin
        m_active = 1;
        m_sent   = 0;
        m_target = bus.pkt_target;
        m_size   = int'(bus.pkt_size);
      end
      if (bus.wr_en) begin
        if (c_full) m_ovf = 1;
        else        exp_q.push_back(bus.wr_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_flit(input logic [W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic post(input logic [W-1:0] t, input logic [W-1:0] s);
    bus.pkt_valid  = 1'b1;
    bus.pkt_target = t;
    bus.pkt_size   = s;
    tick();
    bus.pkt_valid  = 1'b0;
  endtask

  // Run until the packet completes; optional credit pattern 1,0,0,1,...
  task automatic drain(input bit toggle, input string name);
    for (int i = 0; i < 200; i++) begin
      if (!m_active) break;
      if (toggle) bus.credit_i = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    bus.credit_i = 1'b1;
    check(name, m_active, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    clear_model();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_tail(input string name, input int base,
                            input logic [W-1:0] lits[$]);
    check({name, "_len"}, out_log.size() - base, lits.size());
    for (int i = 0; i < lits.size(); i++)
      if (base + i < out_log.size())
        check(name, out_log[base + i], lits[i]);
  endtask

  // ---------------- directed stimulus ----------------
  logic [W-1:0] t1 [5] = '{16'h0011, 16'h0003, 16'hA001, 16'hB002, 16'hC003};
  int base;

  initial begin
    bus.pkt_valid = 0; bus.pkt_target = '0; bus.pkt_size = '0;
    bus.wr_en = 0; bus.wr_data = '0; bus.credit_i = 1'b1;
    clear_model();
    #2;
    check("rst_tx", bus.tx, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_ready", bus.pkt_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_full", bus.fifo_full, 0);
    check("rst_ovf", bus.overflow, 0);
    tick(); tick();
    reset = 1'b1;

    // 1: pre-filled size-3 packet, five back-to-back flits
    write_flit(16'hA001); write_flit(16'hB002); write_flit(16'hC003);
    base = out_log.size();
    post(16'h0011, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t1_tx", bus.tx, 1);
      check("t1_flit", bus.data_out, t1[i]);
      tick();
    end
    @(negedge clock);
    check("t1_ready", bus.pkt_ready, 1);
    check("t1_tx_low", bus.tx, 0);
    tick();
    check_tail("t1_log", base, '{16'h0011, 16'h0003, 16'hA001, 16'hB002, 16'hC003});

    // 2: size 0 -> two flits, FIFO untouched
    write_flit(16'hD004);
    base = out_log.size();
    post(16'h0022, 16'h0000);
    drain(0, "t2_done");
    @(negedge clock);
    check("t2_count", bus.fifo_count, 1);
    tick();
    check_tail("t2_log", base, '{16'h0022, 16'h0000});

    // 3: credit toggling on a 4-flit payload
    write_flit(16'hE005); write_flit(16'hF006); write_flit(16'h1007);
    base = out_log.size();
    post(16'h0033, 16'h0004);
    drain(1, "t3_done");
    tick();
    check_tail("t3_log", base,
               '{16'h0033, 16'h0004, 16'hD004, 16'hE005, 16'hF006, 16'h1007});

    // 4: empty FIFO, late writes produce bubbles
    base = out_log.size();
    post(16'h0044, 16'h0002);
    tick(); tick();
    @(negedge clock);
    check("t4_bubble_tx", bus.tx, 0);
    check("t4_bubble_busy", bus.busy, 1);
    write_flit(16'h4401);
    tick();
    write_flit(16'h4402);
    drain(0, "t4_done");
    tick();
    check_tail("t4_log", base, '{16'h0044, 16'h0002, 16'h4401, 16'h4402});

    // 5a: overflow with a plain write while full
    for (int i = 0; i < DEPTH; i++) write_flit(W'(16'h5000 + i));
    write_flit(16'hBAD1);
    @(negedge clock);
    check("t5_full", bus.fifo_full, 1);
    check("t5_ovf", bus.overflow, 1);
    check("t5_count", bus.fifo_count, 8);
    tick();
    base = out_log.size();
    post(16'h0055, 16'h0008);
    drain(0, "t5_done");
    tick();
    check_tail("t5_log", base, '{16'h0055, 16'h0008, 16'h5000, 16'h5001, 16'h5002,
               16'h5003, 16'h5004, 16'h5005, 16'h5006, 16'h5007});

    // 5b: write while full coinciding with a pop is still dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) write_flit(W'(16'h5100 + i));
    base = out_log.size();
    post(16'h0056, 16'h0003);
    tick(); tick();
    bus.wr_en = 1'b1; bus.wr_data = 16'hBAD2;
    tick();
    bus.wr_en = 1'b0;
    @(negedge clock);
    check("t5b_ovf", bus.overflow, 1);
    check("t5b_count", bus.fifo_count, 7);
    tick();
    drain(0, "t5b_done");
    tick();
    check_tail("t5b_log", base, '{16'h0056, 16'h0003, 16'h5100, 16'h5101, 16'h5102});

    // 6: reset in PAYLOAD with two flits left, then a clean packet
    do_reset();
    for (int i = 0; i < 4; i++) write_flit(W'(16'h6000 + i));
    post(16'h0060, 16'h0004);
    tick(); tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check("t6_tx", bus.tx, 0);
    check("t6_count", bus.fifo_count, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_ready", bus.pkt_ready, 1);
    check("t6_data", bus.data_out, 0);
    clear_model();
    tick();
    reset = 1'b1;
    write_flit(16'h6100);
    base = out_log.size();
    post(16'h0066, 16'h0001);
    drain(0, "t6_done");
    tick();
    check_tail("t6_log", base, '{16'h0066, 16'h0001, 16'h6100});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/phoenix_ni_tx.md
# phoenix_ni_tx

Network-interface transmitter for the local port of the Phoenix router. A host/IP core posts a packet descriptor (target address, payload length) and pushes payload flits into an internal FIFO. The block then serialises the packet onto the router's local input using the credit-based rx/data_in/credit_o handshake: header flit, size flit, then payload flits. It is the injecting end of the link that the router's local-port buffer receives.

## Interface
Parameters:
- TAM_FLIT, 16, flit width in bits; matches the router flit width.
- DEPTH, 8, payload FIFO depth in flits; power of two, minimum 2.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  descriptor valid.
- pkt_ready  out  1  descriptor accepted when pkt_valid && pkt_ready at the clock edge.
- pkt_target  in  TAM_FLIT  target router address; sent as the header flit.
- pkt_size  in  TAM_FLIT  payload flit count; sent as the size flit.
- wr_en  in  1  payload FIFO write strobe.
- wr_data  in  TAM_FLIT  payload flit.
- fifo_full  out  1  FIFO holds DEPTH flits.
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; set by a write while full.
- busy  out  1  packet in progress (state != IDLE).
- clock_tx  out  1  equals clock; drives the router clock_rx.
- tx  out  1  flit valid toward the router rx.
- data_out  out  TAM_FLIT  flit toward the router data_in.
- credit_i  in  1  router credit_o; a flit transfers on the edge where tx && credit_i.

## Operation
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
- IDLE:
  - pkt_ready=1, tx=0.
  - On descriptor accept, latch target and size into registers and go to HEADER.
- HEADER:
  - tx=1, data_out=latched target.
  - On transfer, go to SIZE.
- SIZE:
  - tx=1, data_out=latched size.
  - On transfer: if size==0, go to IDLE; otherwise load the remaining counter with size and go to PAYLOAD.
- PAYLOAD:
  - tx = FIFO not empty; data_out = FIFO head (first-word-fall-through).
  - Each transfer pops the FIFO and decrements remaining.
  - A transfer with remaining==1 returns the FSM to IDLE.
  - If the FIFO empties mid-packet, tx=0 (bubble) until data arrives. The packet is never truncated.
- tx, once asserted, stays high with data_out stable until the transfer occurs. When credit_i=0, hold everything.
- The payload FIFO accepts writes in any state, so the host may preload it before posting the descriptor.
- Write with fifo_full=1:
  - The write is dropped and overflow is set.
  - fifo_full is evaluated at the start of the cycle, so the write is dropped even if a pop occurs in the same cycle.
- Simultaneous write and pop when not full: both take effect and fifo_count is unchanged.
- Pointers wrap modulo DEPTH. fifo_count ranges over 0..DEPTH.
- The remaining counter is TAM_FLIT bits wide. pkt_size=2^TAM_FLIT-1 is legal.
- data_out when tx=0: holds its last value; 0 after reset.

## Timing
- Reset values (asserted asynchronously, immediately):
  - state IDLE, tx=0, data_out=0, pkt_ready=1, busy=0.
  - FIFO empty, fifo_count=0, fifo_full=0, overflow=0.
  - clock_tx follows clock throughout.
- Reset mid-packet aborts the packet: tx drops at once and the FIFO is flushed.
- Descriptor accepted at edge N: tx=1 with header from N+1.
- With credit_i held 1 and the FIFO pre-filled, a size-S packet occupies S+2 consecutive transfer cycles, then pkt_ready=1 on the following cycle.
- Throughput is one flit per cycle maximum. The IDLE gap between packets is exactly 1 cycle.
- FIFO write at edge N: the flit is visible at the head and counted from N+1.
- overflow clears only on reset.

## Test plan
- Pre-fill 3 flits A,B,C; post target=0x0011, size=3; credit_i=1 -> tx high for 5 consecutive cycles carrying 0x0011, 0x0003, A, B, C; pkt_ready back high on cycle 6.
- size=0, target=0x0022 -> exactly 2 flits (0x0022, 0x0000), then IDLE; FIFO content untouched.
- credit_i toggles 1,0,0,1,... during a 4-flit payload -> data_out stable while credit_i=0, no flit duplicated or skipped, total 6 transfers.
- Post size=2 with an empty FIFO, write the first flit 3 cycles later and the second 5 cycles later -> tx=0 bubbles while empty, busy=1 throughout, packet completes correctly.
- Fill to DEPTH=8, write a 9th flit -> fifo_full=1, overflow=1, fifo_count=8, ninth flit absent from the output; the same overflow result when a pop coincides with the write.
- Assert reset while in PAYLOAD with 2 flits remaining -> tx=0 and fifo_count=0 immediately; after release, a new packet transmits cleanly.
